// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller with a frame FSM, 3-sample majority vote,
// LSB-first deserializer and parity/stop checking.
// Ports: clk/rst_n (async active-low); RX_IN serial line (idle high); Prescale clocks per bit;
// PAR_EN/PAR_TYP parity enable and type (0 even, 1 odd); edge_cnt/bit_cnt from the external
// edge/bit counter; cnt_enable drives that counter; P_DATA last good word; data_valid,
// par_err, stp_err are 1-cycle result strobes.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX_IN,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [4:0]             edge_cnt,
    input  logic [3:0]             bit_cnt,
    output logic                   cnt_enable,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  s0, s1, s2, perr;
    logic [5:0]            mid, ec;
    logic                  dec, bitv;
    assign mid        = 6'(Prescale >> 1);
    assign ec         = {1'b0, edge_cnt};
    assign dec        = ec == mid + 6'd2;
    assign bitv       = (s0 & s1) | (s1 & s2) | (s0 & s2);
    // The counter is held clear whenever the FSM is idle, so each start edge resynchronises it.
    assign cnt_enable = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            perr       <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state != IDLE) begin
                if (ec == mid - 6'd1) s0 <= RX_IN;
                if (ec == mid) s1 <= RX_IN;
                if (ec == mid + 6'd1) s2 <= RX_IN;
            end
            case (state)
                IDLE: if (!RX_IN) begin
                    state <= START;
                    perr  <= 1'b0;
                end
                START: state <= (dec && bitv) ? IDLE : (bit_cnt == 4'd1) ? DATA : START;
                DATA: begin
                    if (dec) shreg <= {bitv, shreg[DATA_WIDTH-1:1]};
                    if (bit_cnt == 4'(DATA_WIDTH + 1)) state <= PAR_EN ? PARITY : STOP;
                end
                PARITY: begin
                    if (dec) perr <= bitv != (^shreg ^ PAR_TYP);
                    if (bit_cnt == 4'(DATA_WIDTH + 2)) state <= STOP;
                end
                STOP: if (dec) begin
                    state <= IDLE;
                    if (perr) par_err <= 1'b1;
                    else if (!bitv) stp_err <= 1'b1;
                    else begin
                        P_DATA     <= shreg;
                        data_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a local edge/bit counter model.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic       glt = 1'b0;
    logic       rx;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       cnt_enable, data_valid, par_err, stp_err;
    logic [7:0] p_data;
    int         total = 0, bad = 0;
    int         nv = 0, np = 0, ns = 0;
    int         v0, p0, q0;
    assign rx = line ^ glt;
    always #5 clk = ~clk;
    uart_rx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .RX_IN(rx), .Prescale(prescale), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .cnt_enable(cnt_enable),
        .P_DATA(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if ({1'b0, edge_cnt} == prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else edge_cnt <= edge_cnt + 5'd1;
    end
    always @(negedge clk) begin
        if (data_valid) nv++;
        if (par_err) np++;
        if (stp_err) ns++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic snap();
        v0 = nv;
        p0 = np;
        q0 = ns;
    endtask
    task automatic chk_strobes(input string tag, input int ev, input int ep, input int es);
        chk({tag, "_valid"}, nv - v0, ev);
        chk({tag, "_perr"}, np - p0, ep);
        chk({tag, "_serr"}, ns - q0, es);
    endtask
    task automatic hold();
        repeat (int'(prescale)) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] d, input logic pb, input logic sb);
        line = 1'b0;
        hold();
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            hold();
        end
        if (par_en) begin
            line = pb;
            hold();
        end
        line = sb;
        hold();
        line = 1'b1;
    endtask
    initial begin
        logic hit;
        repeat (3) @(negedge clk);
        chk("rst_pdata", p_data, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_perr", par_err, 1'b0);
        chk("rst_serr", stp_err, 1'b0);
        chk("rst_en", cnt_enable, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        snap();
        send(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("t1", 1, 0, 0);
        chk("t1_pdata", p_data, 8'hA5);
        chk("t1_en", cnt_enable, 1'b0);
        prescale = 6'd16;
        par_en = 1'b1;
        snap();
        send(8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("t2a", 1, 0, 0);
        chk("t2a_pdata", p_data, 8'h3C);
        snap();
        send(8'h3D, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("t2b", 0, 1, 0);
        chk("t2b_pdata", p_data, 8'h3C);
        par_typ = 1'b1;
        snap();
        send(8'h3D, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("t2c", 1, 0, 0);
        chk("t2c_pdata", p_data, 8'h3D);
        prescale = 6'd32;
        par_en = 1'b0;
        par_typ = 1'b0;
        snap();
        send(8'h81, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk_strobes("t3a", 0, 0, 1);
        chk("t3a_pdata", p_data, 8'h3D);
        chk("t3a_en", cnt_enable, 1'b0);
        snap();
        send(8'h7E, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("t3b", 1, 0, 0);
        chk("t3b_pdata", p_data, 8'h7E);
        prescale = 6'd8;
        snap();
        line = 1'b0;
        repeat (2) @(negedge clk);
        line = 1'b1;
        chk("t4_en_on", cnt_enable, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_en_off", cnt_enable, 1'b0);
        chk_strobes("t4", 0, 0, 0);
        chk("t4_pdata", p_data, 8'h7E);
        prescale = 6'd16;
        snap();
        hit = 1'b0;
        fork
            send(8'h55, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (bit_cnt == 4'd4 && edge_cnt == 5'd8) begin
                        hit = 1'b1;
                        break;
                    end
                end
                glt = 1'b1;
                @(negedge clk);
                glt = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("t5_hit", hit, 1'b1);
        chk_strobes("t5", 1, 0, 0);
        chk("t5_pdata", p_data, 8'h55);
        snap();
        hit = 1'b0;
        fork
            send(8'hFF, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (bit_cnt == 4'd5) begin
                        hit = 1'b1;
                        break;
                    end
                end
                rst_n = 1'b0;
                #1;
                chk("t6_rst_pdata", p_data, 8'h00);
                chk("t6_rst_en", cnt_enable, 1'b0);
                chk("t6_rst_valid", data_valid, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("t6_hit", hit, 1'b1);
        chk_strobes("t6a", 0, 0, 0);
        chk("t6a_pdata", p_data, 8'h00);
        snap();
        send(8'hF0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("t6b", 1, 0, 0);
        chk("t6b_pdata", p_data, 8'hF0);
        prescale = 6'd8;
        snap();
        send(8'h12, 1'b0, 1'b1);
        chk("b2b_first", p_data, 8'h12);
        send(8'h34, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk_strobes("b2b", 2, 0, 0);
        chk("b2b_pdata", p_data, 8'h34);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
